sata_pattern_test_seq: RTL

Self-test sequencer for the SATA data path. Writes bursts of an incrementing byte pattern to the link, requests read-back, and checks the returned stream byte-by-byte. Counts mismatches and timeouts, then reports pass/fail. Sits between the test control registers and the link's byte-wide write/read ports, and sequences the same incrementing pattern (0x00 reserved as don't-care) used by the link-side data checker.

---
 rtl/sata_test_pkg.sv | 32 +++
 rtl/sata_pattern_gen.sv | 39 +++
 rtl/sata_pattern_test_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sata_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sata_test_pkg
//  Description : Shared types and constants for the SATA pattern self-test
//                sequencer. Provides the sequencer state encoding, the first
//                pattern byte, the "no error captured" index marker and the
//                pattern step function (0xFF wraps to 0x01; 0x00 is never
//                produced because the link-side checker treats it as
//                don't-care).
//  Revision    : 1.0 - initial release
// ============================================================================
package sata_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_GAP    = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD     = 3'd4,
        ST_NEXT   = 3'd5,
        ST_FIN    = 3'd6
    } state_t;

    localparam logic [7:0]  PATTERN_FIRST = 8'h01;
    localparam logic [15:0] IDX_NONE      = 16'hFFFF;

    function automatic logic [7:0] next_pattern(input logic [7:0] cur);
        return (cur == 8'hFF) ? PATTERN_FIRST : cur + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sata_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sata_pattern_gen
//  Description : Incrementing byte pattern source, 0x01..0xFF then back to
//                0x01. Used both for the write stream and for the expected
//                read-back stream.
//  Ports       : clk     - system clock
//                nRST    - asynchronous active-low reset (pattern -> 0x01)
//                load    - restart pattern at 0x01 (wins over advance)
//                advance - step to the next pattern byte
//                pattern - current pattern byte
//  Revision    : 1.0 - initial release
// ============================================================================
module sata_pattern_gen
    import sata_test_pkg::*;
(
    input  logic       clk,
    input  logic       nRST,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] pattern
);

    logic [7:0] r_pattern;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_pattern <= PATTERN_FIRST;
        end else if (load) begin
            r_pattern <= PATTERN_FIRST;
        end else if (advance) begin
            r_pattern <= next_pattern(r_pattern);
        end
    end

    assign pattern = r_pattern;

endmodule
`default_nettype wire

// File: rtl/sata_pattern_test_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sata_pattern_test_seq
//  Description : SATA data-path self-test sequencer. Writes NUM_BURSTS bursts
//                of BURST_LEN incrementing pattern bytes, requests read-back
//                after each burst, checks the returned bytes and reports
//                mismatches, read-back stalls and an overall pass flag.
//  Ports       : clk, nRST           - clock, async active-low reset
//                start, abort        - run control (abort wins)
//                wr_data/valid/ready - byte write stream to the link
//                rd_req              - one-cycle read-back request
//                rd_data, rd_ack     - returned byte stream
//                busy, done, pass    - run status / result
//                timeout             - read-back stalled (sticky)
//                err_cnt             - saturating mismatch count
//                first_err_idx       - in-burst index of first mismatch
//                burst_cnt           - completed bursts in this run
//  Revision    : 1.0 - initial release
// ============================================================================
module sata_pattern_test_seq
    import sata_test_pkg::*;
#(
    parameter int unsigned BURST_LEN  = 512,
    parameter int unsigned NUM_BURSTS = 16,
    parameter int unsigned GAP_CYCLES = 32,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        start,
    input  logic        abort,
    output logic [7:0]  wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic        rd_req,
    input  logic [7:0]  rd_data,
    input  logic        rd_ack,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_cnt,
    output logic [15:0] first_err_idx,
    output logic [15:0] burst_cnt
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_idx;        // byte index within the current burst (write or read phase)
    logic [31:0] r_cyc;        // shared gap / read-stall cycle counter
    logic        r_pass;
    logic        r_timeout;
    logic [15:0] r_err_cnt;
    logic [15:0] r_first_err;
    logic [15:0] r_burst_cnt;
    logic [7:0]  w_exp;

    logic w_start, w_abort, w_wr_fire, w_rd_ack, w_last_idx;
    logic w_mismatch, w_tmo, w_gap_done, w_final, w_reload;

    // abort only has effect outside IDLE; start is dropped when abort is high
    assign w_abort    = abort && (r_state != ST_IDLE);
    assign w_start    = start && !abort && (r_state == ST_IDLE);
    assign w_wr_fire  = (r_state == ST_WR) && wr_ready;
    assign w_rd_ack   = (r_state == ST_RD) && rd_ack;
    assign w_last_idx = (r_idx == 16'(BURST_LEN - 1));
    assign w_mismatch = w_rd_ack && (rd_data != w_exp);
    assign w_tmo      = (r_state == ST_RD) && !rd_ack && (r_cyc == 32'(TIMEOUT - 1));
    assign w_gap_done = (r_cyc == 32'(GAP_CYCLES - 1));
    assign w_final    = ((r_burst_cnt + 16'd1) == 16'(NUM_BURSTS));
    assign w_reload   = w_start || (r_state == ST_NEXT);

    sata_pattern_gen u_wr_gen (
        .clk     (clk),
        .nRST    (nRST),
        .load    (w_reload),
        .advance (w_wr_fire),
        .pattern (wr_data)
    );

    sata_pattern_gen u_exp_gen (
        .clk     (clk),
        .nRST    (nRST),
        .load    (w_reload),
        .advance (w_rd_ack),
        .pattern (w_exp)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        wr_valid    = 1'b0;
        rd_req      = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_start) w_state_nxt = ST_WR;
            end
            ST_WR: begin
                wr_valid = 1'b1;
                if (w_wr_fire && w_last_idx)
                    w_state_nxt = (GAP_CYCLES == 0) ? ST_RD_REQ : ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_done) w_state_nxt = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                rd_req      = 1'b1;
                w_state_nxt = ST_RD;
            end
            ST_RD: begin
                if (w_rd_ack && w_last_idx) w_state_nxt = ST_NEXT;
                else if (w_tmo)             w_state_nxt = ST_FIN;
            end
            ST_NEXT: begin
                w_state_nxt = w_final ? ST_FIN : ST_WR;
            end
            ST_FIN: begin
                done        = 1'b1;
                busy        = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_idx       <= 16'd0;
            r_cyc       <= 32'd0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_cnt   <= 16'd0;
            r_first_err <= IDX_NONE;
            r_burst_cnt <= 16'd0;
        end else if (w_abort) begin
            // counters are left as they are so the aborted run can be inspected
            r_pass <= 1'b0;
        end else begin
            if (w_start) begin
                r_idx       <= 16'd0;
                r_pass      <= 1'b0;
                r_timeout   <= 1'b0;
                r_err_cnt   <= 16'd0;
                r_first_err <= IDX_NONE;
                r_burst_cnt <= 16'd0;
            end
            case (r_state)
                ST_WR: begin
                    r_cyc <= 32'd0;
                    if (w_wr_fire) r_idx <= w_last_idx ? 16'd0 : r_idx + 16'd1;
                end
                ST_GAP: begin
                    r_cyc <= r_cyc + 32'd1;
                end
                ST_RD_REQ: begin
                    r_cyc <= 32'd0;
                end
                ST_RD: begin
                    if (rd_ack) begin
                        r_cyc <= 32'd0;
                        r_idx <= w_last_idx ? 16'd0 : r_idx + 16'd1;
                        if (w_mismatch) begin
                            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                            if (r_first_err == IDX_NONE) r_first_err <= r_idx;
                        end
                    end else begin
                        r_cyc <= r_cyc + 32'd1;
                    end
                    if (w_tmo) begin
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                    end
                end
                ST_NEXT: begin
                    r_burst_cnt <= r_burst_cnt + 16'd1;
                    // result is latched on the way into FIN so it is valid alongside done
                    if (w_final) r_pass <= (r_err_cnt == 16'd0) && !r_timeout;
                end
                default: ;
            endcase
        end
    end

    assign pass          = r_pass;
    assign timeout       = r_timeout;
    assign err_cnt       = r_err_cnt;
    assign first_err_idx = r_first_err;
    assign burst_cnt     = r_burst_cnt;

endmodule
`default_nettype wire
